// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_pkg
//  Description : Shared definitions for the io_bus master: target select
//                encodings, FSM state enumeration, default timing values
//                and the word-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_bus_pkg;

    // Default timing, in clk_sys cycles
    localparam int c_setup_cycles_default   = 2;
    localparam int c_gap_cycles_default     = 4;
    localparam int c_timeout_cycles_default = 65535;

    // Width of the shared setup/gap/timeout down-counter
    localparam int c_tmr_w = 16;

    // Target select encoding on req_sel
    localparam logic [1:0] c_sel_uio  = 2'd0;
    localparam logic [1:0] c_sel_fpga = 2'd1;
    localparam logic [1:0] c_sel_osd  = 2'd2;
    localparam logic [1:0] c_sel_rsvd = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL    = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STB_HI = 3'd3,
        ST_STB_LO = 3'd4,
        ST_NEXT   = 3'd5,
        ST_GAP    = 3'd6
    } state_t;

    // Narrow responders only see the low byte; the upper byte is zeroed.
    function automatic logic [15:0] fit_word(input logic [15:0] word, input logic wide);
        return wide ? word : {8'h00, word[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_timer
//  Description : Loadable down-counter shared by the setup hold, the
//                inter-transaction gap and the acknowledge timeout.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                i_load          - load i_load_val (has priority over count)
//                i_load_val      - value to load
//                i_count         - decrement by one, saturating at zero
//                o_expire        - counter is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_count,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_master
//  Description : Strobed 16-bit IO bus master. Issues a command word followed
//                by req_len data words to one of three targets, capturing the
//                responder's io_dout for every data word.
//  Ports       : clk_sys, reset            - clock, async active-high reset
//                req_valid/ready, req_sel, req_cmd, req_len - request
//                wr_valid/ready, wr_data   - outbound data words
//                rd_valid, rd_data         - captured responder data
//                done, err                 - completion / abort pulses
//                io_clk, io_din, io_uio, io_fpga, io_osd - bus outputs
//                io_ack, io_dout, io_wide  - responder inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int SETUP_CYCLES   = c_setup_cycles_default,
    parameter int GAP_CYCLES     = c_gap_cycles_default,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles_default
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic [15:0] req_cmd,
    input  logic [7:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        err,
    output logic        io_clk,
    output logic [15:0] io_din,
    output logic        io_uio,
    output logic        io_fpga,
    output logic        io_osd,
    input  logic        io_ack,
    input  logic [15:0] io_dout,
    input  logic        io_wide
);

    // Counter reload values: a state that loads N-1 lasts exactly N cycles.
    localparam logic [c_tmr_w-1:0] c_setup_ld   = c_tmr_w'(SETUP_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_gap_ld     = c_tmr_w'(GAP_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_timeout_ld = c_tmr_w'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [15:0]        r_cmd;
    logic [7:0]         r_remaining;
    logic               r_is_data;

    logic               w_tmr_load;
    logic [c_tmr_w-1:0] w_tmr_val;
    logic               w_tmr_count;
    logic               w_tmr_expire;

    io_bus_timer #(
        .WIDTH      (c_tmr_w)
    ) u_timer (
        .clk        (clk_sys),
        .rst        (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_count    (w_tmr_count),
        .o_expire   (w_tmr_expire)
    );

    // Timer control mirrors the FSM transitions below: every transition
    // into a timed state reloads the counter for that state.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_count = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_ready && req_valid && (req_sel == c_sel_rsvd)) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_gap_ld;
                end
            end
            ST_SEL: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = c_setup_ld;
            end
            ST_SETUP: begin
                if (w_tmr_expire) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_timeout_ld;
                end else begin
                    w_tmr_count = 1'b1;
                end
            end
            ST_STB_HI: begin
                if (io_ack) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_timeout_ld;
                end else if (w_tmr_expire) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_gap_ld;
                end else begin
                    w_tmr_count = 1'b1;
                end
            end
            ST_STB_LO: begin
                if (io_ack) begin
                    if (w_tmr_expire) begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_gap_ld;
                    end else begin
                        w_tmr_count = 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                if (r_remaining == '0) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_gap_ld;
                end else if (wr_valid && wr_ready) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_setup_ld;
                end
            end
            ST_GAP: begin
                w_tmr_count = 1'b1;
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_cmd       <= '0;
            r_remaining <= '0;
            r_is_data   <= 1'b0;
            req_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            io_clk      <= 1'b0;
            io_din      <= '0;
            io_uio      <= 1'b0;
            io_fpga     <= 1'b0;
            io_osd      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_ready && req_valid) begin
                        req_ready   <= 1'b0;
                        r_sel       <= req_sel;
                        r_cmd       <= req_cmd;
                        r_remaining <= req_len;
                        r_is_data   <= 1'b0;
                        if (req_sel == c_sel_rsvd) begin
                            err     <= 1'b1;
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_SEL;
                        end
                    end else begin
                        // Covers the first cycle after reset release
                        req_ready <= 1'b1;
                    end
                end
                ST_SEL: begin
                    io_uio  <= (r_sel == c_sel_uio);
                    io_fpga <= (r_sel == c_sel_fpga);
                    io_osd  <= (r_sel == c_sel_osd);
                    io_din  <= fit_word(r_cmd, io_wide);
                    r_state <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (w_tmr_expire) begin
                        io_clk  <= 1'b1;
                        r_state <= ST_STB_HI;
                    end
                end
                ST_STB_HI: begin
                    if (io_ack) begin
                        io_clk <= 1'b0;
                        // Command-strobe read data is meaningless and dropped
                        if (r_is_data) begin
                            rd_valid <= 1'b1;
                            rd_data  <= io_dout;
                        end
                        r_state <= ST_STB_LO;
                    end else if (w_tmr_expire) begin
                        io_clk  <= 1'b0;
                        io_uio  <= 1'b0;
                        io_fpga <= 1'b0;
                        io_osd  <= 1'b0;
                        err     <= 1'b1;
                        r_state <= ST_GAP;
                    end
                end
                ST_STB_LO: begin
                    if (!io_ack) begin
                        wr_ready <= (r_remaining != '0);
                        r_state  <= ST_NEXT;
                    end else if (w_tmr_expire) begin
                        io_uio  <= 1'b0;
                        io_fpga <= 1'b0;
                        io_osd  <= 1'b0;
                        err     <= 1'b1;
                        r_state <= ST_GAP;
                    end
                end
                ST_NEXT: begin
                    if (r_remaining == '0) begin
                        io_uio  <= 1'b0;
                        io_fpga <= 1'b0;
                        io_osd  <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_GAP;
                    end else if (wr_valid && wr_ready) begin
                        io_din      <= fit_word(wr_data, io_wide);
                        wr_ready    <= 1'b0;
                        r_remaining <= r_remaining - 1'b1;
                        r_is_data   <= 1'b1;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_GAP: begin
                    if (w_tmr_expire) begin
                        // Raised here so req_ready is visible on IDLE entry
                        req_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bus_master
//  Description : Self-checking bench for io_bus_master with a responder model
//                (ack follows io_clk by two cycles, io_dout = io_din ^ KEY)
//                and scoreboard queues for strobed words and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_io_bus_master;

    localparam int          SETUP_CYCLES   = 2;
    localparam int          GAP_CYCLES     = 4;
    localparam int          TIMEOUT_CYCLES = 16;
    localparam logic [15:0] KEY            = 16'hC3C3;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_sel = '0;
    logic [15:0] req_cmd = '0;
    logic [7:0]  req_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        done;
    logic        err;
    logic        io_clk;
    logic [15:0] io_din;
    logic        io_uio;
    logic        io_fpga;
    logic        io_osd;
    logic        io_ack  = 1'b0;
    logic [15:0] io_dout = '0;
    logic        io_wide = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_din_q[$];
    logic [15:0] exp_rd_q[$];
    logic [2:0]  exp_sel_vec = 3'b000;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          rd_cnt   = 0;
    int          rise_cnt = 0;
    bit          mon_en   = 1'b0;
    bit          resp_mute = 1'b0;
    int          resp_stretch = 0;

    always #5 clk_sys = ~clk_sys;

    io_bus_master #(
        .SETUP_CYCLES   (SETUP_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_cmd   (req_cmd),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .io_clk    (io_clk),
        .io_din    (io_din),
        .io_uio    (io_uio),
        .io_fpga   (io_fpga),
        .io_osd    (io_osd),
        .io_ack    (io_ack),
        .io_dout   (io_dout),
        .io_wide   (io_wide)
    );

    // Responder: ack is io_clk delayed by two edges (plus optional stretch)
    logic [7:0] clk_hist = '0;
    always @(posedge clk_sys) begin
        clk_hist <= {clk_hist[6:0], io_clk};
        if (io_clk && !clk_hist[0]) io_dout <= io_din ^ KEY;
        io_ack <= !resp_mute && clk_hist[resp_stretch];
    end

    // Monitor: scoreboard pops on strobes and read pulses
    logic        prev_clk = 1'b0;
    logic [15:0] prev_din = '0;
    logic [15:0] mon_exp;
    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (io_clk && !prev_clk) begin
                rise_cnt++;
                checks++;
                if (exp_din_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: io_din=%h sel=%b, required no strobe", io_din, {io_osd, io_fpga, io_uio});
                end else begin
                    mon_exp = exp_din_q.pop_front();
                    if (io_din !== mon_exp) begin
                        errors++;
                        $display("FAIL strobe_din: got %h, required %h", io_din, mon_exp);
                    end
                end
                checks++;
                if ({io_osd, io_fpga, io_uio} !== exp_sel_vec) begin
                    errors++;
                    $display("FAIL strobe_select: got %b, required %b", {io_osd, io_fpga, io_uio}, exp_sel_vec);
                end
            end
            if (io_clk && prev_clk) begin
                checks++;
                if (io_din !== prev_din) begin
                    errors++;
                    $display("FAIL din_stable: io_din %h -> %h while io_clk high", prev_din, io_din);
                end
            end
            if (rd_valid) begin
                rd_cnt++;
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: rd_data=%h, required no rd_valid", rd_data);
                end else begin
                    mon_exp = exp_rd_q.pop_front();
                    if (rd_data !== mon_exp) begin
                        errors++;
                        $display("FAIL rd_data: got %h, required %h", rd_data, mon_exp);
                    end
                end
            end
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (rd_valid || done || err) begin
                checks++;
                if ((int'(rd_valid) + int'(done) + int'(err)) > 1) begin
                    errors++;
                    $display("FAIL pulse_exclusive: rd_valid=%b done=%b err=%b, required at most one", rd_valid, done, err);
                end
            end
        end
        prev_clk = io_clk;
        prev_din = io_din;
    end

    // ---------------------------------------------------------------- drivers
    task automatic start_req(input logic [1:0] sel, input logic [15:0] cmd, input logic [7:0] len);
        int t;
        @(negedge clk_sys);
        req_sel   = sel;
        req_cmd   = cmd;
        req_len   = len;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, t);
        end
        @(negedge clk_sys);
        req_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [15:0] d, input int hold);
        int t;
        bit bad;
        t = 0;
        while (!wr_ready && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready_wait: wr_ready=%b after %0d cycles, required 1", wr_ready, t);
        end
        if (hold > 0) begin
            bad = 1'b0;
            repeat (hold) begin
                if (io_clk !== 1'b0 || wr_ready !== 1'b1 || err !== 1'b0 ||
                    {io_osd, io_fpga, io_uio} !== exp_sel_vec) bad = 1'b1;
                @(negedge clk_sys);
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL next_hold: io_clk/wr_ready/err/select disturbed while stalled, required 0/1/0/%b", exp_sel_vec);
            end
        end
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge clk_sys);
        wr_valid = 1'b0;
    endtask

    task automatic wait_end(output bit got_done, output bit got_err);
        int t;
        got_done = 1'b0;
        got_err  = 1'b0;
        t = 0;
        while (t < 300) begin
            if (done) got_done = 1'b1;
            if (err)  got_err  = 1'b1;
            if (got_done || got_err) break;
            @(negedge clk_sys);
            t++;
        end
    endtask

    // Called on the cycle done/err is visible; counts cycles until req_ready
    task automatic check_gap();
        int n;
        bit bad;
        n = 0;
        bad = 1'b0;
        while (!req_ready && n < 20) begin
            if (io_uio || io_fpga || io_osd || io_clk) bad = 1'b1;
            n++;
            @(negedge clk_sys);
        end
        checks++;
        if (n != GAP_CYCLES) begin
            errors++;
            $display("FAIL gap_length: got %0d cycles, required %0d", n, GAP_CYCLES);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL gap_idle: select or io_clk high during gap, required all low");
        end
    endtask

    task automatic check_counts(input string name, input int rises, input int rds,
                                input int dones, input int errs,
                                input int b_rise, input int b_rd, input int b_done, input int b_err);
        checks++;
        if ((rise_cnt - b_rise) != rises || (rd_cnt - b_rd) != rds ||
            (done_cnt - b_done) != dones || (err_cnt - b_err) != errs) begin
            errors++;
            $display("FAIL %s_counts: strobes/rd/done/err got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                     name, rise_cnt - b_rise, rd_cnt - b_rd, done_cnt - b_done, err_cnt - b_err,
                     rises, rds, dones, errs);
        end
        checks++;
        if (exp_din_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d strobes and %0d reads outstanding, required 0/0",
                     name, exp_din_q.size(), exp_rd_q.size());
        end
    endtask

    // -------------------------------------------------------------- scenarios
    task automatic test_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({req_ready, io_clk, io_osd, io_fpga, io_uio, rd_valid, done, err, wr_ready} !== 9'b0 ||
            io_din !== 16'h0 || rd_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b io_din=%h rd_data=%h, required all 0",
                     {req_ready, io_clk, io_osd, io_fpga, io_uio, rd_valid, done, err, wr_ready}, io_din, rd_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: got %b, required 0 before first edge", req_ready);
        end
        @(negedge clk_sys);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: got %b, required 1 after first edge", req_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        int b_rise, b_rd, b_done, b_err;
        bit gd, ge;
        b_rise = rise_cnt; b_rd = rd_cnt; b_done = done_cnt; b_err = err_cnt;
        io_wide = 1'b1;
        exp_sel_vec = 3'b001;
        exp_din_q.push_back(16'h0001);
        exp_din_q.push_back(16'h00A5);
        exp_rd_q.push_back(16'h00A5 ^ KEY);
        start_req(2'd0, 16'h0001, 8'd1);
        feed_word(16'h00A5, 0);
        wait_end(gd, ge);
        checks++;
        if (gd !== 1'b1 || ge !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: done=%b err=%b, required 1/0", gd, ge);
        end
        check_gap();
        check_counts("basic", 2, 1, 1, 0, b_rise, b_rd, b_done, b_err);
    endtask

    task automatic test_narrow();
        int b_rise, b_rd, b_done, b_err;
        bit gd, ge;
        b_rise = rise_cnt; b_rd = rd_cnt; b_done = done_cnt; b_err = err_cnt;
        io_wide = 1'b0;
        resp_stretch = 2;
        exp_sel_vec = 3'b001;
        exp_din_q.push_back(16'h0034);
        exp_din_q.push_back(16'h00EF);
        exp_din_q.push_back(16'h0001);
        exp_rd_q.push_back(16'h00EF ^ KEY);
        exp_rd_q.push_back(16'h0001 ^ KEY);
        start_req(2'd0, 16'h1234, 8'd2);
        feed_word(16'hBEEF, 0);
        feed_word(16'h5501, 0);
        wait_end(gd, ge);
        checks++;
        if (gd !== 1'b1 || ge !== 1'b0) begin
            errors++;
            $display("FAIL narrow_end: done=%b err=%b, required 1/0", gd, ge);
        end
        check_gap();
        check_counts("narrow", 3, 2, 1, 0, b_rise, b_rd, b_done, b_err);
        io_wide = 1'b1;
        resp_stretch = 0;
    endtask

    task automatic test_cmd_only();
        int b_rise, b_rd, b_done, b_err;
        bit gd, ge;
        b_rise = rise_cnt; b_rd = rd_cnt; b_done = done_cnt; b_err = err_cnt;
        exp_sel_vec = 3'b100;
        exp_din_q.push_back(16'h80C3);
        start_req(2'd2, 16'h80C3, 8'd0);
        wait_end(gd, ge);
        checks++;
        if (gd !== 1'b1 || ge !== 1'b0) begin
            errors++;
            $display("FAIL cmd_only_end: done=%b err=%b, required 1/0", gd, ge);
        end
        check_gap();
        check_counts("cmd_only", 1, 0, 1, 0, b_rise, b_rd, b_done, b_err);
    endtask

    task automatic test_timeout();
        int b_rise, b_rd, b_done, b_err;
        int t, hi;
        b_rise = rise_cnt; b_rd = rd_cnt; b_done = done_cnt; b_err = err_cnt;
        resp_mute = 1'b1;
        exp_sel_vec = 3'b010;
        exp_din_q.push_back(16'h0F0F);
        start_req(2'd1, 16'h0F0F, 8'd0);
        t = 0;
        while (!io_clk && t < 50) begin
            @(negedge clk_sys);
            t++;
        end
        hi = 0;
        while (io_clk && hi < 100) begin
            hi++;
            @(negedge clk_sys);
        end
        checks++;
        if (hi != TIMEOUT_CYCLES) begin
            errors++;
            $display("FAIL timeout_len: io_clk high %0d cycles, required %0d", hi, TIMEOUT_CYCLES);
        end
        checks++;
        if (err !== 1'b1 || io_fpga !== 1'b0 || io_clk !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: err=%b io_fpga=%b io_clk=%b done=%b, required 1/0/0/0",
                     err, io_fpga, io_clk, done);
        end
        check_gap();
        resp_mute = 1'b0;
        check_counts("timeout", 1, 0, 0, 1, b_rise, b_rd, b_done, b_err);
    endtask

    task automatic test_stall();
        int b_rise, b_rd, b_done, b_err;
        bit gd, ge;
        b_rise = rise_cnt; b_rd = rd_cnt; b_done = done_cnt; b_err = err_cnt;
        exp_sel_vec = 3'b010;
        exp_din_q.push_back(16'h0102);
        exp_din_q.push_back(16'h3C3C);
        exp_rd_q.push_back(16'h3C3C ^ KEY);
        start_req(2'd1, 16'h0102, 8'd1);
        feed_word(16'h3C3C, 50);
        wait_end(gd, ge);
        checks++;
        if (gd !== 1'b1 || ge !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: done=%b err=%b, required 1/0", gd, ge);
        end
        check_gap();
        check_counts("stall", 2, 1, 1, 0, b_rise, b_rd, b_done, b_err);
    endtask

    task automatic test_reset_mid();
        int b_err, b_done, t;
        bit gd, ge;
        b_err = err_cnt; b_done = done_cnt;
        exp_sel_vec = 3'b001;
        exp_din_q.push_back(16'h0A0A);
        exp_din_q.push_back(16'h1111);
        start_req(2'd0, 16'h0A0A, 8'd2);
        feed_word(16'h1111, 0);
        t = 0;
        while (!io_clk && t < 50) begin
            @(negedge clk_sys);
            t++;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, io_clk, io_osd, io_fpga, io_uio, rd_valid, done, err, wr_ready} !== 9'b0 ||
            io_din !== 16'h0 || rd_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: ctl=%b io_din=%h rd_data=%h, required all 0",
                     {req_ready, io_clk, io_osd, io_fpga, io_uio, rd_valid, done, err, wr_ready}, io_din, rd_data);
        end
        exp_din_q.delete();
        exp_rd_q.delete();
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (req_ready !== 1'b1 || err_cnt != b_err) begin
            errors++;
            $display("FAIL reset_mid_recover: req_ready=%b err pulses=%0d, required 1/0", req_ready, err_cnt - b_err);
        end
        // Reserved target: abort with no select and no strobe
        start_req(2'd3, 16'h7777, 8'd1);
        wait_end(gd, ge);
        checks++;
        if (ge !== 1'b1 || gd !== 1'b0 || {io_osd, io_fpga, io_uio} !== 3'b000) begin
            errors++;
            $display("FAIL rsvd_sel: err=%b done=%b sel=%b, required 1/0/000",
                     ge, gd, {io_osd, io_fpga, io_uio});
        end
        check_gap();
        checks++;
        if ((err_cnt - b_err) != 1 || (done_cnt - b_done) != 0) begin
            errors++;
            $display("FAIL rsvd_counts: err=%0d done=%0d, required 1/0", err_cnt - b_err, done_cnt - b_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_narrow();
        test_cmd_only();
        test_timeout();
        test_stall();
        test_reset_mid();
        repeat (5) @(negedge clk_sys);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: clk_sys cycles that io_din is held stable before each io_clk rise.
REQ-002 Parameter GAP_CYCLES, default 4: idle cycles with all selects low between transactions.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: maximum cycles to wait for any io_ack edge.
REQ-004 clk_sys  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 req_valid  in  1  transaction request; req_ready  out  1  request accepted when both are high.
REQ-007 req_sel  in  2  target select: 0=uio, 1=fpga, 2=osd, 3=reserved.
REQ-008 req_cmd  in  16  command word; req_len  in  8  data words following the command (0 is legal).
REQ-009 wr_valid  in  1 / wr_ready  out  1 / wr_data  in  16  outbound data-word stream.
REQ-010 rd_valid  out  1 / rd_data  out  16  one-cycle pulse carrying the io_dout captured for each data word.
REQ-011 done  out  1  one-cycle pulse on normal completion; err  out  1  one-cycle pulse on abort.
REQ-012 io_clk  out  1  strobe; io_din  out  16  word to the responder; io_uio, io_fpga, io_osd  out  1 each  selects.
REQ-013 io_ack  in  1  responder acknowledge; io_dout  in  16  responder data; io_wide  in  1  responder accepts 16-bit words.

Function
REQ-014 States: IDLE, SEL, SETUP, STB_HI, STB_LO, NEXT, GAP.
REQ-015 IDLE: req_ready=1. On accept, latch req_*, go to SEL. req_sel=3 -> err pulse, go to GAP with no select asserted.
REQ-016 SEL: assert the selected line (exactly one), drive io_din=command, go to SETUP. The select stays high through STB_LO of the last word.
REQ-017 SETUP: hold io_din for SETUP_CYCLES, then go to STB_HI.
REQ-018 STB_HI: io_clk=1. When io_ack=1, capture io_dout. For a data word, pulse rd_valid with rd_data. Then go to STB_LO.
REQ-019 STB_LO: io_clk=0. When io_ack=0, go to NEXT.
REQ-020 NEXT: if words remain, wr_ready=1. On wr_valid, latch wr_data into io_din and go to SETUP; while wr_valid is low, stay and keep io_clk=0. If no words remain, deassert the select, pulse done, go to GAP.
REQ-021 Word width: when io_wide=0, io_din[15:8] is forced to 0 (sampled per word at SETUP entry).
REQ-022 Word count: command word plus exactly req_len data words. req_len=0 issues the command strobe only.
REQ-023 io_dout captured during the command strobe is discarded (no rd_valid).
REQ-024 Timeout: a counter resets on entry to STB_HI and STB_LO. Reaching TIMEOUT_CYCLES without the awaited io_ack level -> drop io_clk and all selects, pulse err, go to GAP. NEXT has no timeout.
REQ-025 GAP: all selects low, io_clk=0, for GAP_CYCLES, then IDLE.
REQ-026 rd_valid, done, err are never asserted in the same cycle as one another.
REQ-027 io_clk never rises while no select is high.
REQ-028 io_din changes only while io_clk=0.

Reset
REQ-029 On reset assertion, go immediately to IDLE. io_clk=0, all selects=0, io_din=0, rd_valid=done=err=0, wr_ready=0, rd_data=0, counters=0.
REQ-030 Reset mid-transaction aborts it silently (no err pulse).
REQ-031 req_ready rises the first clk_sys edge after reset deasserts.

Structure
REQ-032 The select encoding constants, state enumeration and default parameter values live in shared package io_bus_pkg.
REQ-033 The wait/timeout and setup/gap down-counter is one sub-module, io_bus_timer (load, count, expire).
REQ-034 All io_* outputs are driven directly from registers (no combinational paths from inputs).

Verification
REQ-035 Bench responder is modelled as: ack follows io_clk by 2 cycles, with optional wait stretching.
REQ-036 Scenario: sel=0, cmd=0x0001, len=1, wr_data=0x00A5, io_wide=1 -> io_uio high, two strobes with io_din 0x0001 then 0x00A5, one rd_valid, one done, io_uio low for 4 cycles.
REQ-037 Scenario: io_wide=0, cmd=0x1234, len=2, data 0xBEEF/0x5501 -> io_din 0x0034, 0x00EF, 0x0001; rd_data equals the model's io_dout per word.
REQ-038 Scenario: len=0, sel=2 -> single strobe on io_osd, no rd_valid, done pulse.
REQ-039 Scenario: responder never raises ack, TIMEOUT_CYCLES=16 -> err on cycle 16 of STB_HI, io_clk and io_fpga drop the same cycle, no done.
REQ-040 Scenario: wr_valid withheld for 50 cycles in NEXT -> io_clk stays 0, select held, no err; the transfer then completes normally.
REQ-041 Scenario: reset asserted during STB_HI of word 2 -> all outputs 0 asynchronously, no err, req_ready=1 the first edge after release; sel=3 request -> err, no select asserted.
